// File: rtl/dmem_bus_bridge.sv
// Bridges the data-memory stage's single-cycle port onto a valid/ready request
// bus with variable-latency responses, stalling the pipeline while an access is in flight.
module dmem_bus_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [31:0] mem_a,
    input  logic [31:0] mem_wd,
    input  logic [3:0]  mem_wmask,
    output logic [31:0] mem_rd,
    output logic        stall,
    output logic        mem_fault,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_wmask,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_rdata,
    input  logic        bus_resp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] mem_rd_q, mem_rd_d;
    logic        fault_q, fault_d;
    logic        valid_q, valid_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;

    logic        access_s;
    logic [16:0] cnt_inc_s;
    logic        timed_out_s;

    assign access_s    = mem_re | mem_we;
    assign cnt_inc_s   = {1'b0, cnt_q} + 17'd1;
    assign timed_out_s = (cnt_inc_s >= TIMEOUT_W);

    // Next-state, request capture, timeout counting and response handling.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_rd_d = mem_rd_q;
        fault_d  = 1'b0;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        case (state_q)
            S_IDLE: begin
                if (access_s) begin
                    we_d    = mem_we;
                    addr_d  = {mem_a[31:2], 2'b00};
                    wdata_d = mem_wd;
                    wmask_d = mem_we ? mem_wmask : 4'b0000;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    cnt_d   = 16'd0;
                    state_d = S_RESP;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_RESP: begin
                if (bus_resp_valid) begin
                    if (!we_q) begin
                        mem_rd_d = bus_resp_err ? 32'd0 : bus_resp_rdata;
                    end else begin
                        mem_rd_d = mem_rd_q;
                    end
                    fault_d = bus_resp_err;
                    state_d = S_DONE;
                end else if (timed_out_s) begin
                    // A missing response is reported exactly like an error response.
                    if (!we_q) begin
                        mem_rd_d = 32'd0;
                    end else begin
                        mem_rd_d = mem_rd_q;
                    end
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_inc_s[15:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        valid_d = (state_d == S_REQ);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            mem_rd_q <= 32'd0;
            fault_q  <= 1'b0;
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            wmask_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_rd_q <= mem_rd_d;
            fault_q  <= fault_d;
            valid_q  <= valid_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
        end
    end

    // Stall: access-driven in IDLE, forced through REQ/RESP, released in DONE and in reset.
    always_comb begin
        stall = 1'b0;
        if (reset) begin
            stall = 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  stall = access_s;
                S_REQ:   stall = 1'b1;
                S_RESP:  stall = 1'b1;
                S_DONE:  stall = 1'b0;
                default: stall = 1'b0;
            endcase
        end
    end

    assign mem_rd        = mem_rd_q;
    assign mem_fault     = fault_q;
    assign bus_req_valid = valid_q;
    assign bus_req_we    = we_q;
    assign bus_req_addr  = addr_q;
    assign bus_req_wdata = wdata_q;
    assign bus_req_wmask = wmask_q;

endmodule
